seq_pattern_gen: RTL

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pattern_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repetitions and idle gaps
module seq_pattern_gen #(
   parameter int PAT_WIDTH = 4,
   parameter int GAP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic [3:0]           count,
   output logic                 out,
   output logic                 valid,
   output logic                 busy,
   output logic                 done
);
   localparam int BW = $clog2(PAT_WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
   state_t               state;
   logic [PAT_WIDTH-1:0] pat;
   logic [3:0]           reps;
   logic [BW-1:0]        bidx;
   logic [2:0]           gapc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pat   <= '0;
         reps  <= '0;
         bidx  <= '0;
         gapc  <= '0;
         out   <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && !abort) begin
               pat  <= pattern;
               reps <= count;
               if (count == 4'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= SHIFT;
                  bidx  <= BW'(PAT_WIDTH-1);
                  out   <= pattern[PAT_WIDTH-1];
                  valid <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            // bidx is the index of the bit currently on out
            SHIFT: if (abort) begin
               state <= IDLE;
               out   <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end else if (bidx != '0) begin
               bidx <= bidx - BW'(1);
               out  <= pat[bidx - BW'(1)];
            end else if (reps == 4'd1) begin
               state <= DONE;
               reps  <= 4'd0;
               out   <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else if (GAP_BITS == 0) begin
               reps <= reps - 4'd1;
               bidx <= BW'(PAT_WIDTH-1);
               out  <= pat[PAT_WIDTH-1];
            end else begin
               state <= GAP;
               reps  <= reps - 4'd1;
               gapc  <= 3'(GAP_BITS-1);
               out   <= 1'b0;
               valid <= 1'b0;
            end
            GAP: if (abort) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (gapc == 3'd0) begin
               state <= SHIFT;
               bidx  <= BW'(PAT_WIDTH-1);
               out   <= pat[PAT_WIDTH-1];
               valid <= 1'b1;
            end else begin
               gapc <= gapc - 3'd1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
